// File: rtl/int_arb_pkg.sv
// ---------------------------------------------------------------------------
// int_arb_pkg
//
// Shared definitions for the eight-channel interrupt arbiter:
//   NCH          - number of interrupt channels
//   VW           - width of the encoded vector
//   arbState_e   - controller states (idle / offering a vector / in service)
//   idx_to_vec   - channel index to vector code (channel 7 maps to code 0)
//   vec_to_onehot- vector code back to a one-hot channel mask
// ---------------------------------------------------------------------------
package int_arb_pkg;

   localparam int NCH = 8;
   localparam int VW  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_SVC   = 2'd2
   } arbState_e;

   // Higher channel numbers have higher priority, so the vector code counts
   // down from the top channel: ch7 -> 0, ch0 -> 7.
   function automatic logic [VW-1:0] idx_to_vec(input logic [VW-1:0] n);
      return VW'(NCH - 1) - n;
   endfunction

   // Inverse of idx_to_vec, expanded to a one-hot channel mask. Used to clear
   // exactly the pending bit of the channel being accepted.
   function automatic logic [NCH-1:0] vec_to_onehot(input logic [VW-1:0] v);
      logic [VW-1:0] ch;
      ch = VW'(NCH - 1) - v;
      return NCH'(1) << ch;
   endfunction

endpackage

// File: rtl/int_pri_enc.sv
// ---------------------------------------------------------------------------
// int_pri_enc
//
// Combinational 8:3 priority pick over the effective (pending and unmasked)
// request vector. Channel 7 has the highest priority.
//
// Ports:
//   eff_i  in  [NCH-1:0]  effective requests, active-high, bit n = channel n
//   vec_o  out [VW-1:0]   vector code of the winning channel (7 - n);
//                         0 when nothing is requesting
//   any_o  out            at least one effective request is present
// ---------------------------------------------------------------------------
module int_pri_enc
   import int_arb_pkg::*;
(
   input  logic [NCH-1:0] eff_i,
   output logic [VW-1:0]  vec_o,
   output logic           any_o
);

   // Scan from channel 0 upwards so that the last (highest) set bit found
   // overwrites any lower ones, which gives channel 7 the win.
   always_comb begin
      vec_o = '0;
      for (int i = 0; i < NCH; i++) begin
         if (eff_i[i]) begin
            vec_o = idx_to_vec(VW'(i));
         end
      end
      any_o = |eff_i;
   end

endmodule

// File: rtl/int_arbiter8.sv
// ---------------------------------------------------------------------------
// int_arbiter8
//
// Eight-channel interrupt arbiter. Active-low requests are captured (either
// on their falling edge or as a level), masked, and the highest-priority
// pending channel is offered to a CPU-side consumer as a 3-bit vector over
// an int / ack / end-of-interrupt handshake. Arbitration can be chained with
// other arbiters through the active-low iEI / oEO pair.
//
// Parameters:
//   EDGE_TRIG   1 = pending bit set on a falling edge of iReq[n]
//               0 = pending[n] simply follows ~iReq[n] every cycle
//   RESET_MASK  mask register value after reset (1 = channel masked)
//
// Ports:
//   iClk     in       clock, all state updates on the rising edge
//   iRst     in       synchronous active-high reset
//   iReq     in  [8]  request lines, active-low, bit n = channel n
//   iEI      in       chain enable in, active-low (1 disables arbitration)
//   iMask    in  [8]  mask write data
//   iMaskWe  in       load iMask into the mask register at the edge
//   iAck     in       consumer accepts the offered vector
//   iEoi     in       end of service for the in-service channel
//   oInt     out      interrupt offered, oVector valid
//   oVector  out [3]  encoded channel (7 - n)
//   oBusy    out      a channel is in service
//   oEO      out      chain enable out, active-low
// ---------------------------------------------------------------------------
module int_arbiter8
   import int_arb_pkg::*;
#(
   parameter bit             EDGE_TRIG  = 1'b1,
   parameter logic [NCH-1:0] RESET_MASK = 8'h00
) (
   input  logic           iClk,
   input  logic           iRst,
   input  logic [NCH-1:0] iReq,
   input  logic           iEI,
   input  logic [NCH-1:0] iMask,
   input  logic           iMaskWe,
   input  logic           iAck,
   input  logic           iEoi,
   output logic           oInt,
   output logic [VW-1:0]  oVector,
   output logic           oBusy,
   output logic           oEO
);

   arbState_e      state_q,   state_d;
   logic [NCH-1:0] req_q;
   logic [NCH-1:0] pending_q, pending_d;
   logic [NCH-1:0] mask_q,    mask_d;
   logic [VW-1:0]  vec_q,     vec_d;
   logic           int_q,     int_d;
   logic           busy_q,    busy_d;
   logic [VW-1:0]  insvc_q,   insvc_d;

   logic [NCH-1:0] eff;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] clr;
   logic [VW-1:0]  encVec;
   logic           encAny;

   // Only unmasked pending channels take part in arbitration. The mask is a
   // register, so a write becomes visible here one cycle after it lands.
   assign eff = pending_q & ~mask_q;

   int_pri_enc uPriEnc (
      .eff_i (eff),
      .vec_o (encVec),
      .any_o (encAny)
   );

   // Controller: pick a channel while idle, hold the chosen vector steady
   // while it is offered, and wait for end-of-interrupt while in service.
   // Once in OFFER the vector is frozen, so later requests or mask changes
   // cannot swap the channel under the consumer. Dropping the chain enable
   // withdraws the offer and wins over a simultaneous acknowledge; the
   // pending bit is left alone so the same channel is offered again later.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      int_d   = int_q;
      busy_d  = busy_q;
      insvc_d = insvc_q;
      clr     = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (!iEI && encAny) begin
               vec_d   = encVec;
               int_d   = 1'b1;
               state_d = ST_OFFER;
            end
         end

         ST_OFFER: begin
            if (iEI) begin
               int_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (iAck) begin
               clr     = vec_to_onehot(vec_q);
               insvc_d = VW'(NCH - 1) - vec_q;
               int_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_SVC;
            end
         end

         ST_SVC: begin
            if (iEoi) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            int_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request capture. In edge mode a falling edge is seen as "was high last
   // cycle, low now"; OR-ing the new edges in after the clear means a fresh
   // edge on the channel being acknowledged is not lost. In level mode the
   // pending vector simply mirrors the request pins and the clear is moot.
   always_comb begin
      fall = req_q & ~iReq;
      if (EDGE_TRIG) begin
         pending_d = (pending_q & ~clr) | fall;
      end else begin
         pending_d = ~iReq;
      end
      mask_d = iMaskWe ? iMask : mask_q;
   end

   // State register with synchronous reset. req_q resets to all-high so that
   // a request already low when reset drops is seen as a fresh edge.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q   <= ST_IDLE;
         req_q     <= '1;
         pending_q <= '0;
         mask_q    <= RESET_MASK;
         vec_q     <= '0;
         int_q     <= 1'b0;
         busy_q    <= 1'b0;
         insvc_q   <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= iReq;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         vec_q     <= vec_d;
         int_q     <= int_d;
         busy_q    <= busy_d;
         insvc_q   <= insvc_d;
      end
   end

   // The chain passes enable downstream only when this arbiter is enabled,
   // idle, and has nothing eligible to offer.
   assign oEO     = ~(~iEI && (state_q == ST_IDLE) && !encAny);
   assign oInt    = int_q;
   assign oVector = vec_q;
   assign oBusy   = busy_q;

endmodule

// File: tb/tb_int_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_int_arbiter8
//
// Drives an edge-triggered and a level-triggered arbiter with identical
// stimulus (directed scenarios, then randomized traffic) and compares both
// against a channel-level reference model.
// ---------------------------------------------------------------------------
module tb_int_arbiter8;

   logic       iClk;
   logic       iRst;
   logic [7:0] iReq;
   logic       iEI;
   logic [7:0] iMask;
   logic       iMaskWe;
   logic       iAck;
   logic       iEoi;

   logic [1:0] oInt;
   logic [1:0] oBusy;
   logic [1:0] oEO;
   logic [2:0] oVector [2];

   int errors = 0;
   int checks = 0;

   // Reference model, index 0 = edge mode, index 1 = level mode.
   bit [7:0] mPend    [2];
   bit [7:0] mPrevReq [2];
   bit [7:0] mMask    [2];
   bit       mOffer   [2];
   bit       mServe   [2];
   int       mCh      [2];

   int_arbiter8 #(.EDGE_TRIG(1'b1), .RESET_MASK(8'h00)) dutEdge (
      .iClk    (iClk),
      .iRst    (iRst),
      .iReq    (iReq),
      .iEI     (iEI),
      .iMask   (iMask),
      .iMaskWe (iMaskWe),
      .iAck    (iAck),
      .iEoi    (iEoi),
      .oInt    (oInt[0]),
      .oVector (oVector[0]),
      .oBusy   (oBusy[0]),
      .oEO     (oEO[0])
   );

   int_arbiter8 #(.EDGE_TRIG(1'b0), .RESET_MASK(8'h00)) dutLevel (
      .iClk    (iClk),
      .iRst    (iRst),
      .iReq    (iReq),
      .iEI     (iEI),
      .iMask   (iMask),
      .iMaskWe (iMaskWe),
      .iAck    (iAck),
      .iEoi    (iEoi),
      .oInt    (oInt[1]),
      .oVector (oVector[1]),
      .oBusy   (oBusy[1]),
      .oEO     (oEO[1])
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset(input int m);
      mPend[m]    = 8'h00;
      mPrevReq[m] = 8'hFF;
      mMask[m]    = 8'h00;
      mOffer[m]   = 1'b0;
      mServe[m]   = 1'b0;
      mCh[m]      = 7;
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic modelStep(input int m, input bit rst, input bit [7:0] req,
                            input bit ei, input bit maskWe, input bit [7:0] mask,
                            input bit ack, input bit eoi);
      bit [7:0] eff;
      bit [7:0] clear;
      bit       found;
      eff   = mPend[m] & ~mMask[m];
      clear = 8'h00;
      found = 1'b0;
      if (rst) begin
         modelReset(m);
         return;
      end
      if (!mOffer[m] && !mServe[m]) begin
         if (!ei && eff != 8'h00) begin
            for (int i = 7; i >= 0; i--) begin
               if (eff[i] && !found) begin
                  mCh[m] = i;
                  found  = 1'b1;
               end
            end
            mOffer[m] = 1'b1;
         end
      end else if (mOffer[m]) begin
         if (ei) begin
            mOffer[m] = 1'b0;
         end else if (ack) begin
            clear[mCh[m]] = 1'b1;
            mOffer[m] = 1'b0;
            mServe[m] = 1'b1;
         end
      end else if (eoi) begin
         mServe[m] = 1'b0;
      end
      if (m == 0) mPend[m] = (mPend[m] & ~clear) | (mPrevReq[m] & ~req);
      else        mPend[m] = ~req;
      mPrevReq[m] = req;
      if (maskWe) mMask[m] = mask;
   endtask

   // One clock cycle: drive inputs after the falling edge, check the
   // combinational chain output, step the model, then check the registered
   // outputs just after the rising edge.
   task automatic applyStimulus(input bit rst, input bit [7:0] req, input bit ei,
                                input bit maskWe, input bit [7:0] mask,
                                input bit ack, input bit eoi);
      bit expEO;
      @(negedge iClk);
      iRst    = rst;
      iReq    = req;
      iEI     = ei;
      iMaskWe = maskWe;
      iMask   = mask;
      iAck    = ack;
      iEoi    = eoi;
      #1;
      for (int m = 0; m < 2; m++) begin
         expEO = !(!ei && !mOffer[m] && !mServe[m] && ((mPend[m] & ~mMask[m]) == 8'h00));
         checkOutput($sformatf("oEO[%0d]", m), 8'(oEO[m]), 8'(expEO));
         modelStep(m, rst, req, ei, maskWe, mask, ack, eoi);
      end
      @(posedge iClk);
      #1;
      for (int m = 0; m < 2; m++) begin
         checkOutput($sformatf("oInt[%0d]", m),    8'(oInt[m]),    8'(mOffer[m]));
         checkOutput($sformatf("oBusy[%0d]", m),   8'(oBusy[m]),   8'(mServe[m]));
         checkOutput($sformatf("oVector[%0d]", m), 8'(oVector[m]), 8'(7 - mCh[m]));
      end
   endtask

   // Shorthand for a normal cycle with the chain enabled and no mask write.
   task automatic cycleReq(input bit [7:0] req, input bit ack, input bit eoi);
      applyStimulus(1'b0, req, 1'b0, 1'b0, 8'h00, ack, eoi);
   endtask

   initial begin
      bit [7:0] rReq;
      iRst = 1'b1; iReq = 8'hFF; iEI = 1'b0; iMask = 8'h00;
      iMaskWe = 1'b0; iAck = 1'b0; iEoi = 1'b0;
      modelReset(0);
      modelReset(1);

      // Reset, then a single channel-2 request through the full handshake.
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("reset oInt", 8'(oInt[0]), 8'h00);
      checkOutput("reset oVector", 8'(oVector[0]), 8'h00);
      cycleReq(8'hFB, 1'b0, 1'b0);
      checkOutput("ch2 not yet offered", 8'(oInt[0]), 8'h00);
      cycleReq(8'hFB, 1'b0, 1'b0);
      checkOutput("ch2 offered", 8'(oInt[0]), 8'h01);
      checkOutput("ch2 vector", 8'(oVector[0]), 8'h05);
      cycleReq(8'hFB, 1'b1, 1'b0);
      checkOutput("ch2 busy", 8'(oBusy[0]), 8'h01);
      cycleReq(8'hFF, 1'b0, 1'b1);
      checkOutput("ch2 done", 8'(oBusy[0]), 8'h00);

      // Priority pick and vector freeze while offered.
      cycleReq(8'hBD, 1'b0, 1'b0);
      cycleReq(8'hBD, 1'b0, 1'b0);
      checkOutput("ch6 over ch1", 8'(oVector[0]), 8'h01);
      cycleReq(8'h3D, 1'b0, 1'b0);
      checkOutput("vector frozen", 8'(oVector[0]), 8'h01);
      cycleReq(8'h3D, 1'b1, 1'b0);
      cycleReq(8'h3D, 1'b0, 1'b1);
      cycleReq(8'h3D, 1'b0, 1'b0);
      checkOutput("ch7 next", 8'(oVector[0]), 8'h00);
      cycleReq(8'h3D, 1'b1, 1'b0);
      cycleReq(8'h3D, 1'b0, 1'b1);
      cycleReq(8'hFF, 1'b0, 1'b0);
      checkOutput("ch1 last", 8'(oVector[0]), 8'h06);
      cycleReq(8'hFF, 1'b1, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycleReq(8'hFF, 1'b0, 1'b0);

      // Masking: a masked channel is not offered until the mask is lifted.
      applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
      cycleReq(8'hBF, 1'b0, 1'b0);
      cycleReq(8'hBF, 1'b0, 1'b0);
      checkOutput("masked ch6", 8'(oInt[0]), 8'h00);
      applyStimulus(1'b0, 8'hBF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      cycleReq(8'hBF, 1'b0, 1'b0);
      checkOutput("unmasked ch6", 8'(oVector[0]), 8'h01);
      cycleReq(8'hBF, 1'b1, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b1);

      // Withdraw: chain disable together with ack, then re-offer.
      cycleReq(8'hEF, 1'b0, 1'b0);
      cycleReq(8'hEF, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hEF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("withdrawn", 8'(oInt[0]), 8'h00);
      checkOutput("withdrawn not busy", 8'(oBusy[0]), 8'h00);
      applyStimulus(1'b0, 8'hEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cycleReq(8'hEF, 1'b0, 1'b0);
      checkOutput("re-offer ch4", 8'(oVector[0]), 8'h03);
      cycleReq(8'hEF, 1'b1, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b1);

      // Set beats clear on a fresh ch3 edge coinciding with ack.
      cycleReq(8'hF7, 1'b0, 1'b0);
      cycleReq(8'hF7, 1'b0, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b0);
      cycleReq(8'hF7, 1'b1, 1'b0);
      cycleReq(8'hF7, 1'b0, 1'b1);
      cycleReq(8'hF7, 1'b0, 1'b0);
      checkOutput("ch3 re-offered", 8'(oVector[0]), 8'h04);
      checkOutput("ch3 re-offered int", 8'(oInt[0]), 8'h01);
      cycleReq(8'hF7, 1'b1, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b1);

      // Held ch0: level mode re-offers after one idle cycle, edge mode does not.
      cycleReq(8'hFE, 1'b0, 1'b0);
      cycleReq(8'hFE, 1'b0, 1'b0);
      cycleReq(8'hFE, 1'b1, 1'b0);
      cycleReq(8'hFE, 1'b0, 1'b1);
      checkOutput("level idle gap", 8'(oInt[1]), 8'h00);
      cycleReq(8'hFE, 1'b0, 1'b0);
      checkOutput("level re-offer", 8'(oInt[1]), 8'h01);
      checkOutput("level re-offer vec", 8'(oVector[1]), 8'h07);
      checkOutput("edge no re-offer", 8'(oInt[0]), 8'h00);
      cycleReq(8'hFE, 1'b1, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b1);
      cycleReq(8'hFF, 1'b0, 1'b0);
      cycleReq(8'hFF, 1'b0, 1'b0);
      checkOutput("level released", 8'(oInt[1]), 8'h00);

      // Reset while in service.
      cycleReq(8'hFE, 1'b0, 1'b0);
      cycleReq(8'hFE, 1'b0, 1'b0);
      cycleReq(8'hFE, 1'b1, 1'b0);
      checkOutput("level in service", 8'(oBusy[1]), 8'h01);
      applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("reset clears busy", 8'(oBusy[1]), 8'h00);
      checkOutput("reset clears int", 8'(oInt[1]), 8'h00);
      cycleReq(8'hFF, 1'b0, 1'b0);

      // Randomized traffic.
      rReq = 8'hFF;
      for (int n = 0; n < 1500; n++) begin
         rReq = rReq ^ 8'($urandom & $urandom & $urandom);
         applyStimulus($urandom_range(0, 99) == 0, rReq,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 19) == 0, 8'($urandom & $urandom),
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/int_arbiter8.md
Name: int_arbiter8

Overview:
- Eight-channel interrupt arbiter/controller sequencing an 8:3 active-low priority encoder datapath.
- Captures active-low requests, applies a mask, and selects the highest-priority pending channel. Channel 7 is highest; vector code = 7 − channel, so ch7→3'b000 and ch0→3'b111.
- Presents the vector to a CPU-side consumer over an int/ack/end-of-interrupt handshake.
- Supports daisy-chaining through active-low iEI/oEO, in the same style as the encoder.

Parameters:
- EDGE_TRIG, 1: 1 = pending bit set on falling edge of iReq[n]; 0 = level mode, pending[n] tracks ~iReq[n] each cycle.
- RESET_MASK, 8'h00: mask register value after reset; 1 = channel masked.

Ports:
- iClk, in, 1: the single clock; all state updates on the rising edge.
- iRst, in, 1: synchronous, active-high reset.
- iReq, in, 8: request lines, active-low, bit n = channel n.
- iEI, in, 1: chain enable, active-low; 1 disables arbitration.
- iMask, in, 8: mask write data.
- iMaskWe, in, 1: when 1, the mask register loads iMask at the edge.
- iAck, in, 1: consumer accepts the offered vector.
- iEoi, in, 1: end of service for the in-service channel.
- oInt, out, 1: interrupt offered; oVector valid.
- oVector, out, 3: encoded channel (7 − n).
- oBusy, out, 1: a channel is in service.
- oEO, out, 1: chain enable out, active-low.

Behaviour:
Reset (iRst=1 at an edge):
- state=IDLE, pending=0, req_q=8'hFF, mask=RESET_MASK.
- oInt=0, oVector=3'b000, oBusy=0, insvc=0.
- oEO is combinational: it equals iEI while in reset state.

Request capture:
- EDGE_TRIG=1: req_q<=iReq every cycle. fall=req_q & ~iReq. pending<=(pending & ~clr) | fall.
- Set beats clear when both hit the same bit in the same cycle.
- EDGE_TRIG=0: pending<=~iReq. clr has no effect.
- eff = pending & ~mask. A mask write takes effect from the next cycle.

FSM:
- IDLE:
  - if iEI==0 and eff!=0: latch chosen channel c = highest set bit of eff, oVector<=7−c, oInt<=1, go to OFFER.
  - otherwise stay.
- OFFER (oInt=1, oVector frozen; later mask or pending changes are ignored):
  - iEI==1: withdraw. oInt<=0, go to IDLE, pending kept. Takes priority over iAck in the same cycle.
  - iAck==1: clr=one-hot(c), insvc<=c, oInt<=0, oBusy<=1, go to SVC.
- SVC:
  - iAck ignored. New requests accumulate in pending.
  - iEoi==1: oBusy<=0, go to IDLE. The next offer can appear at the following edge, giving one IDLE cycle minimum.
- iEoi outside SVC is ignored.
- Reset in any state returns to the reset values at that edge.

oEO:
- oEO = 0 iff iEI==0 and state==IDLE and eff==0; otherwise 1.

Latency (edge mode):
- iReq falls before edge k → pending set at edge k → oInt=1 after edge k+1.
- iAck at edge m → oInt=0 and oBusy=1 after edge m.

Decomposition:
- Shared package int_arb_pkg:
  - NCH=8, VW=3.
  - State encoding: ST_IDLE=2'd0, ST_OFFER=2'd1, ST_SVC=2'd2.
  - Function idx_to_vec(n) = 7−n.
- One natural sub-module: int_pri_enc.
  - Combinational 8→3 priority pick over eff.
  - Outputs vec[2:0] and any (any = eff!=0).
  - Channel 7 wins; instantiated once.

Test Plan:
1. Reset then single edge: iRst=1 for 2 cycles; iEI=0, iReq=8'hFF→8'hFB (ch2 falls) → oInt=1 two edges later, oVector=3'b101. iAck pulse → oInt=0, oBusy=1. iEoi → oBusy=0, pending=0, oEO=0.
2. Priority and freeze: ch1 and ch6 fall together → oVector=3'b001. While in OFFER, ch7 falls → oVector stays 001. After ack+eoi, next offer oVector=3'b000 (ch7), then 3'b110 (ch1).
3. Masking: mask=8'h40 written, ch6 falls → no oInt and oEO=0. Then write mask=8'h00 → oInt=1 with oVector=3'b001 after 1 edge.
4. Chain disable/withdraw: in OFFER drive iEI=1 together with iAck → oInt=0, state IDLE, oBusy=0, pending kept, oEO=1. iEI=0 → re-offer with the same vector.
5. Set/clear collision: ch3 pending and offered; iAck in the same cycle as a new ch3 falling edge (iReq went back high and low) → after SVC+eoi, ch3 is re-offered with oVector=3'b100.
6. Level mode (EDGE_TRIG=0): hold iReq[0]=0 through ack/eoi → re-offer of 3'b111 after a 1-cycle IDLE. Release iReq[0] → no further oInt. Assert iRst mid-SVC → oBusy=0, oInt=0 at that edge.
